// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte requesters.
// Grants one byte per handshake, strobes the UART and tracks busy until the line is free again.
module uart_tx_scheduler #(
    parameter int NREQ         = 2,
    parameter int ID_W         = 1,
    parameter int BUSY_TIMEOUT = 16,
    parameter int GUARD        = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*8-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                uart_transmit,
    output logic [7:0]          uart_tx_byte,
    input  logic                uart_tx_busy,
    output logic [ID_W-1:0]     active_id,
    output logic                busy,
    output logic                timeout_err,
    input  logic                err_clear
);

    localparam int CNT_MAX = (BUSY_TIMEOUT > GUARD) ? BUSY_TIMEOUT : GUARD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LAUNCH     = 3'd1,
        WAIT_BUSY  = 3'd2,
        WAIT_DONE  = 3'd3,
        GUARD_WAIT = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [7:0]        byte_q, byte_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              hi_hit_s, lo_hit_s, grant_en_s;
    logic [ID_W-1:0]   hi_idx_s, lo_idx_s, gnt_idx_s;
    logic [7:0]        gnt_byte_s;
    logic [NREQ-1:0]   req_ready_s;
    logic [CNT_W-1:0]  cnt_inc_s;

    // Round-robin pick: lowest valid index above last, else lowest valid index overall.
    always_comb begin
        hi_hit_s   = 1'b0;
        lo_hit_s   = 1'b0;
        hi_idx_s   = {ID_W{1'b0}};
        lo_idx_s   = {ID_W{1'b0}};
        gnt_byte_s = 8'h00;
        for (int j = NREQ - 1; j >= 0; j--) begin
            lo_idx_s = req_valid[j] ? ID_W'(j) : lo_idx_s;
            lo_hit_s = lo_hit_s | req_valid[j];
            hi_idx_s = (req_valid[j] && (ID_W'(j) > last_q)) ? ID_W'(j) : hi_idx_s;
            hi_hit_s = hi_hit_s | (req_valid[j] && (ID_W'(j) > last_q));
        end
        gnt_idx_s  = hi_hit_s ? hi_idx_s : lo_idx_s;
        grant_en_s = reset && (state_q == IDLE) && lo_hit_s;
        for (int j = 0; j < NREQ; j++) begin
            gnt_byte_s     = (gnt_idx_s == ID_W'(j)) ? req_data[8*j +: 8] : gnt_byte_s;
            req_ready_s[j] = grant_en_s && (gnt_idx_s == ID_W'(j));
        end
    end

    // Next-state logic for the transfer sequencer, counters and sticky error.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        byte_d    = byte_q;
        cnt_d     = cnt_q;
        cnt_inc_s = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        err_d     = err_clear ? 1'b0 : err_q;
        case (state_q)
            IDLE: begin
                if (grant_en_s) begin
                    byte_d  = gnt_byte_s;
                    id_d    = gnt_idx_s;
                    last_d  = gnt_idx_s;
                    state_d = LAUNCH;
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_inc_s >= TO_LAST) begin
                    // Unacknowledged strobe: the byte is dropped, the line still gets its guard gap.
                    err_d   = 1'b1;
                    cnt_d   = GUARD_LD;
                    state_d = GUARD_WAIT;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            WAIT_DONE: begin
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d   = GUARD_LD;
                    state_d = GUARD_WAIT;
                end
            end
            GUARD_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= ID_W'(NREQ - 1);
            id_q    <= {ID_W{1'b0}};
            byte_q  <= 8'h00;
            cnt_q   <= {CNT_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign req_ready     = req_ready_s;
    assign uart_transmit = (state_q == LAUNCH);
    assign uart_tx_byte  = byte_q;
    assign active_id     = id_q;
    assign busy          = (state_q != IDLE);
    assign timeout_err   = err_q;

endmodule
